// File: rtl/cmul_sched_pkg.sv
// Shared definitions for the complex-multiplier round-robin scheduler.
// A result entry is laid out MSB-first as {id, tag, re, img}:
//   img at [FLOAT_W-1:0], re at [2*FLOAT_W-1:FLOAT_W],
//   tag at [2*FLOAT_W+TAG_W-1:2*FLOAT_W], and id in the top ID_W bits.
package cmul_sched_pkg;

    localparam int FLOAT_W = 32;

    localparam int IMG_LSB = 0;
    localparam int RE_LSB  = FLOAT_W;
    localparam int TAG_LSB = 2 * FLOAT_W;

    // Requester index width.
    function automatic int id_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    // Width of one {id, tag, re, img} result entry.
    function automatic int entry_w(input int idw, input int tagw);
        return idw + tagw + 2 * FLOAT_W;
    endfunction

endpackage

// File: rtl/sched_result_fifo.sv
// First-word-fall-through result FIFO.
//   clk_i/rst_ni   : clock, asynchronous active-low reset
//   push_i/data_i  : write one entry (pop in the same cycle frees room when full)
//   pop_i          : consume the head entry while valid_o=1
//   valid_o/head_o : head entry, driven to zero while empty
//   count_o        : current occupancy (0..DEPTH)
module sched_result_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        do_push  = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign valid_o = (count_q != '0);
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && (count_q == CNT_W'(DEPTH)) && !pop_i));

endmodule

// File: rtl/cmul_rr_scheduler.sv
// Round-robin scheduler sharing one fixed-latency pipelined complex multiplier
// between NREQ requesters. Issued slots are tracked with a valid/id/tag
// pipeline; products are captured into a credit-protected result FIFO.
//   req_*      : per-requester valid/ready handshake, operands and tag
//   mul_a_*/b_*: registered operands to the multiplier (a = x, b = w)
//   mul_c_*    : multiplier product, MUL_LAT cycles after the operands
//   res_*      : FWFT result head {id, tag, re, img} with valid/ready
//   busy       : any request in flight or buffered
module cmul_rr_scheduler
    import cmul_sched_pkg::*;
#(
    parameter  int NREQ       = 5,
    parameter  int MUL_LAT    = 12,
    parameter  int TAG_W      = 4,
    parameter  int FIFO_DEPTH = 16,
    localparam int ID_W       = id_w(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*FLOAT_W-1:0] req_x_re,
    input  logic [NREQ*FLOAT_W-1:0] req_x_img,
    input  logic [NREQ*FLOAT_W-1:0] req_w_re,
    input  logic [NREQ*FLOAT_W-1:0] req_w_img,
    input  logic [NREQ*TAG_W-1:0]   req_tag,
    output logic [FLOAT_W-1:0]      mul_a_re,
    output logic [FLOAT_W-1:0]      mul_a_img,
    output logic [FLOAT_W-1:0]      mul_b_re,
    output logic [FLOAT_W-1:0]      mul_b_img,
    input  logic [FLOAT_W-1:0]      mul_c_re,
    input  logic [FLOAT_W-1:0]      mul_c_img,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [ID_W-1:0]         res_id,
    output logic [TAG_W-1:0]        res_tag,
    output logic [FLOAT_W-1:0]      res_re,
    output logic [FLOAT_W-1:0]      res_img,
    output logic                    busy
);

    localparam int ENTRY_W = entry_w(ID_W, TAG_W);
    localparam int OUT_W   = $clog2(FIFO_DEPTH + 1);

    logic [ID_W-1:0]    rr_last_q, rr_last_d, gnt_idx, cand;
    logic               gnt_found, issue, pop;
    logic               credit_ok_q, credit_ok_d;
    logic [OUT_W-1:0]   outstanding_q, outstanding_d;
    logic [FLOAT_W-1:0] a_re_q, a_re_d, a_img_q, a_img_d;
    logic [FLOAT_W-1:0] b_re_q, b_re_d, b_img_q, b_img_d;

    // Stage 0 is loaded together with the operand registers; stage MUL_LAT
    // therefore lines up with the product on mul_c_*.
    logic [MUL_LAT:0]            vld_q, vld_d;
    logic [MUL_LAT:0][ID_W-1:0]  id_q, id_d;
    logic [MUL_LAT:0][TAG_W-1:0] tag_q, tag_d;

    logic [ENTRY_W-1:0] push_data, head;
    logic [OUT_W-1:0]   fifo_count;

    // Search starts just after the last winner; idle requesters cost nothing.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = ID_W'((32'(rr_last_q) + k) % NREQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
        issue     = credit_ok_q && gnt_found;
        req_ready = issue ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;
    end

    assign pop = res_valid && res_ready;

    always_comb begin
        rr_last_d = issue ? gnt_idx : rr_last_q;
        a_re_d    = issue ? req_x_re [gnt_idx*FLOAT_W +: FLOAT_W] : '0;
        a_img_d   = issue ? req_x_img[gnt_idx*FLOAT_W +: FLOAT_W] : '0;
        b_re_d    = issue ? req_w_re [gnt_idx*FLOAT_W +: FLOAT_W] : '0;
        b_img_d   = issue ? req_w_img[gnt_idx*FLOAT_W +: FLOAT_W] : '0;
        vld_d     = {vld_q[MUL_LAT-1:0], issue};
        id_d      = {id_q[MUL_LAT-1:0], gnt_idx};
        tag_d     = {tag_q[MUL_LAT-1:0], req_tag[gnt_idx*TAG_W +: TAG_W]};
        unique case ({issue, pop})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
        // Registered compare of the credit count; held low in reset so no
        // grant can be shown while rst_n is asserted.
        credit_ok_d = (outstanding_d < OUT_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q     <= ID_W'(NREQ - 1);
            credit_ok_q   <= 1'b0;
            outstanding_q <= '0;
            a_re_q        <= '0;
            a_img_q       <= '0;
            b_re_q        <= '0;
            b_img_q       <= '0;
            vld_q         <= '0;
            id_q          <= '0;
            tag_q         <= '0;
        end else begin
            rr_last_q     <= rr_last_d;
            credit_ok_q   <= credit_ok_d;
            outstanding_q <= outstanding_d;
            a_re_q        <= a_re_d;
            a_img_q       <= a_img_d;
            b_re_q        <= b_re_d;
            b_img_q       <= b_img_d;
            vld_q         <= vld_d;
            id_q          <= id_d;
            tag_q         <= tag_d;
        end
    end

    assign mul_a_re  = a_re_q;
    assign mul_a_img = a_img_q;
    assign mul_b_re  = b_re_q;
    assign mul_b_img = b_img_q;

    assign push_data = {id_q[MUL_LAT], tag_q[MUL_LAT], mul_c_re, mul_c_img};

    sched_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (vld_q[MUL_LAT]),
        .data_i  (push_data),
        .pop_i   (pop),
        .valid_o (res_valid),
        .head_o  (head),
        .count_o (fifo_count)
    );

    assign res_id  = head[ENTRY_W-1 -: ID_W];
    assign res_tag = head[TAG_LSB +: TAG_W];
    assign res_re  = head[RE_LSB +: FLOAT_W];
    assign res_img = head[IMG_LSB +: FLOAT_W];
    assign busy    = (outstanding_q != '0);

    a_credit_covers_fifo: assert property (@(posedge clk) disable iff (!rst_n)
        outstanding_q >= fifo_count);

endmodule

// File: tb/tb_cmul_rr_scheduler.sv
module tb_cmul_rr_scheduler;

    localparam int NREQ       = 5;
    localparam int MUL_LAT    = 12;
    localparam int TAG_W      = 4;
    localparam int FIFO_DEPTH = 16;
    localparam int FW         = 32;
    localparam int IDW        = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid, req_ready;
    logic [NREQ*FW-1:0]   req_x_re, req_x_img, req_w_re, req_w_img;
    logic [NREQ*TAG_W-1:0] req_tag;
    logic [FW-1:0]        mul_a_re, mul_a_img, mul_b_re, mul_b_img;
    logic [FW-1:0]        mul_c_re, mul_c_img;
    logic                 res_valid, res_ready;
    logic [IDW-1:0]       res_id;
    logic [TAG_W-1:0]     res_tag;
    logic [FW-1:0]        res_re, res_img;
    logic                 busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cmul_rr_scheduler #(
        .NREQ       (NREQ),
        .MUL_LAT    (MUL_LAT),
        .TAG_W      (TAG_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x_re  (req_x_re),
        .req_x_img (req_x_img),
        .req_w_re  (req_w_re),
        .req_w_img (req_w_img),
        .req_tag   (req_tag),
        .mul_a_re  (mul_a_re),
        .mul_a_img (mul_a_img),
        .mul_b_re  (mul_b_re),
        .mul_b_img (mul_b_img),
        .mul_c_re  (mul_c_re),
        .mul_c_img (mul_c_img),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_tag   (res_tag),
        .res_re    (res_re),
        .res_img   (res_img),
        .busy      (busy)
    );

    // Behavioural single-precision complex multiplier (normal numbers and zero).
    function automatic real sp2r(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:0] == '0) return 0.0;
        d = {b[31], 11'({3'b000, b[30:23]} + 11'd896), b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == '0) return '0;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [63:0] cmul(input logic [31:0] ar, ai, br, bi);
        real xr, xi, yr, yi;
        xr = sp2r(ar); xi = sp2r(ai); yr = sp2r(br); yi = sp2r(bi);
        return {r2sp(xr * yr - xi * yi), r2sp(xr * yi + xi * yr)};
    endfunction

    logic [63:0] prod_now;
    logic [31:0] pr_re [MUL_LAT];
    logic [31:0] pr_im [MUL_LAT];

    assign prod_now = cmul(mul_a_re, mul_a_img, mul_b_re, mul_b_img);

    always @(posedge clk) begin
        pr_re[0] <= prod_now[63:32];
        pr_im[0] <= prod_now[31:0];
        for (int i = 1; i < MUL_LAT; i++) begin
            pr_re[i] <= pr_re[i-1];
            pr_im[i] <= pr_im[i-1];
        end
    end

    assign mul_c_re  = pr_re[MUL_LAT-1];
    assign mul_c_img = pr_im[MUL_LAT-1];

    // Default operands: x_i = (i+1) + j0, w = 1 + j0, tag_i = i + 8,
    // so every product is exactly x_i.
    logic [31:0] xre_tab [NREQ];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic load_defaults();
        for (int i = 0; i < NREQ; i++) begin
            req_x_re [i*FW +: FW]       = xre_tab[i];
            req_x_img[i*FW +: FW]       = '0;
            req_w_re [i*FW +: FW]       = 32'h3F80_0000;
            req_w_img[i*FW +: FW]       = '0;
            req_tag  [i*TAG_W +: TAG_W] = 4'(i + 8);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [NREQ-1:0] valid;
        logic [NREQ-1:0] exp_ready;
        logic [31:0]     exp_a_re;
    } vec_t;

    vec_t vec [12];
    int   cnt;
    int   eid;

    initial begin
        xre_tab[0] = 32'h3F80_0000;
        xre_tab[1] = 32'h4000_0000;
        xre_tab[2] = 32'h4040_0000;
        xre_tab[3] = 32'h4080_0000;
        xre_tab[4] = 32'h40A0_0000;

        // Arbitration vectors starting from reset (requester 0 first).
        vec[0]  = '{5'b00000, 5'b00000, 32'h0};
        vec[1]  = '{5'b11111, 5'b00001, 32'h3F80_0000};
        vec[2]  = '{5'b11111, 5'b00010, 32'h4000_0000};
        vec[3]  = '{5'b10001, 5'b10000, 32'h40A0_0000};
        vec[4]  = '{5'b10001, 5'b00001, 32'h3F80_0000};
        vec[5]  = '{5'b00100, 5'b00100, 32'h4040_0000};
        vec[6]  = '{5'b00011, 5'b00001, 32'h3F80_0000};
        vec[7]  = '{5'b00011, 5'b00010, 32'h4000_0000};
        vec[8]  = '{5'b01010, 5'b01000, 32'h4080_0000};
        vec[9]  = '{5'b01010, 5'b00010, 32'h4000_0000};
        vec[10] = '{5'b00000, 5'b00000, 32'h0};
        vec[11] = '{5'b00001, 5'b00001, 32'h3F80_0000};

        load_defaults();
        rst_n     = 1'b0;
        res_ready = 1'b1;
        req_valid = '1;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_mul_a_re", mul_a_re, 0);
        chk("rst_mul_b_img", mul_b_img, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_re", res_re, 0);
        chk("rst_busy", busy, 0);
        req_valid = '0;
        rst_n     = 1'b1;

        // Single request from requester 2: (1+j2)*(0.5+j0) = 0.5+j1.
        @(negedge clk);
        req_x_re [2*FW +: FW]       = 32'h3F80_0000;
        req_x_img[2*FW +: FW]       = 32'h4000_0000;
        req_w_re [2*FW +: FW]       = 32'h3F00_0000;
        req_w_img[2*FW +: FW]       = 32'h0;
        req_tag  [2*TAG_W +: TAG_W] = 4'hA;
        req_valid = 5'b00100;
        #1 chk("single_grant", req_ready, 5'b00100);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("single_mul_a_re", mul_a_re, 32'h3F80_0000);
        chk("single_mul_a_img", mul_a_img, 32'h4000_0000);
        chk("single_mul_b_re", mul_b_re, 32'h3F00_0000);
        chk("single_busy", busy, 1);
        repeat (12) @(negedge clk);
        #1 chk("single_not_early", res_valid, 0);
        @(negedge clk);
        #1;
        chk("single_res_valid", res_valid, 1);
        chk("single_res_id", res_id, 2);
        chk("single_res_tag", res_tag, 4'hA);
        chk("single_res_re", res_re, 32'h3F00_0000);
        chk("single_res_img", res_img, 32'h3F80_0000);
        @(negedge clk);
        #1;
        chk("single_busy_clear", busy, 0);
        chk("single_res_gone", res_valid, 0);
        load_defaults();

        // Table-driven arbitration.
        do_reset();
        for (int r = 0; r < 12; r++) begin
            @(negedge clk);
            if (r > 0) chk("tbl_mul_a_re", mul_a_re, vec[r-1].exp_a_re);
            req_valid = vec[r].valid;
            #1 chk("tbl_ready", req_ready, vec[r].exp_ready);
        end
        @(negedge clk);
        chk("tbl_mul_a_re_last", mul_a_re, vec[11].exp_a_re);
        req_valid = '0;
        repeat (20) @(negedge clk);
        chk("tbl_drained", busy, 0);

        // All requesters continuously valid: one grant per cycle, in-order results.
        do_reset();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            req_valid = '1;
            #1 chk("stream_grant", req_ready, 5'b1 << (c % 5));
            if (c >= 14) begin
                eid = (c - 14) % 5;
                chk("stream_res_valid", res_valid, 1);
                chk("stream_res_id", res_id, eid);
                chk("stream_res_re", res_re, xre_tab[eid]);
                chk("stream_res_tag", res_tag, eid + 8);
            end
        end
        @(negedge clk);
        req_valid = '0;
        repeat (20) @(negedge clk);
        chk("stream_drained", busy, 0);

        // Requesters 1 and 3 only: together, then alternating.
        do_reset();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c < 10) req_valid = 5'b01010;
            else        req_valid = (c % 2 == 0) ? 5'b00010 : 5'b01000;
            #1;
            if (c < 10) chk("alt_both", req_ready, (c % 2 == 0) ? 5'b00010 : 5'b01000);
            else        chk("alt_single", req_ready, req_valid);
        end
        @(negedge clk);
        req_valid = '0;
        repeat (20) @(negedge clk);

        // Downstream stalled: exactly FIFO_DEPTH transfers, then nothing.
        do_reset();
        res_ready = 1'b0;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            req_valid = '1;
            #1 if (req_ready != '0) cnt++;
        end
        chk("stall_transfers", cnt, FIFO_DEPTH);
        @(negedge clk);
        #1;
        chk("stall_no_grant", req_ready, 0);
        chk("stall_head_valid", res_valid, 1);
        chk("stall_head_id", res_id, 0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        chk("pulse_one_grant", req_ready, 5'b00010);
        chk("pulse_next_head", res_id, 1);
        @(negedge clk);
        #1 chk("pulse_then_none", req_ready, 0);

        // Release: credit runs at FIFO_DEPTH-1 with pop and issue each cycle.
        @(negedge clk);
        res_ready = 1'b1;
        #1;
        chk("release_full", req_ready, 0);
        chk("release_head", res_id, 1);
        for (int c = 1; c < 25; c++) begin
            @(negedge clk);
            #1;
            chk("release_grant", req_ready, 5'b1 << ((c + 1) % 5));
            chk("release_res_valid", res_valid, 1);
            chk("release_res_id", res_id, (c + 1) % 5);
        end

        // Asynchronous reset mid-cycle with requests in flight.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ready", req_ready, 0);
        chk("async_rst_mul_a", mul_a_re, 0);
        chk("async_rst_res_valid", res_valid, 0);
        chk("async_rst_res_id", res_id, 0);
        chk("async_rst_busy", busy, 0);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 2 * MUL_LAT; c++) begin
            @(negedge clk);
            #1 if (res_valid) cnt++;
        end
        chk("async_no_stale", cnt, 0);
        @(negedge clk);
        req_valid = '1;
        #1 chk("async_first_grant", req_ready, 5'b00001);
        @(negedge clk);
        req_valid = '0;
        #1 chk("async_first_mul", mul_a_re, 32'h3F80_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
